spike_packetizer: RTL and testbench

//  Source end of the inter-core spike network. Once per tick, this block takes a core's fired-neuron vector.
//  For each spike it looks up the neuron's destination (core, axon) in a local table.
//  It emits one 34-bit packet per spike toward the router with a valid/ready handshake.
//  It sits between the neuron array of a core and that core's router injection port.

---
 rtl/spike_packetizer.sv | 129 ++++++++++++
 tb/tb_spike_packetizer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_packetizer.sv
// spike_packetizer: turns one tick's fired-neuron vector into a stream of
// routed spike packets. Each set bit of the latched vector is looked up in a
// local destination table. Enabled entries produce one packet in ascending
// neuron order over a valid/ready handshake toward the router.
module spike_packetizer #(
    parameter int NUM_NEURONS = 256,
    parameter int PKT_W       = 34
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             core_id,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_addr,
    input  logic [10:0]            cfg_data,
    input  logic                   tick_start,
    input  logic [3:0]             tick_id,
    input  logic [NUM_NEURONS-1:0] spikes,
    output logic                   pkt_valid,
    output logic [PKT_W-1:0]       pkt_data,
    input  logic                   pkt_ready,
    output logic                   busy,
    output logic                   tick_done,
    output logic                   overrun
);

    localparam int NW = $clog2(NUM_NEURONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r;
    logic [NUM_NEURONS-1:0] pending_r;
    logic [3:0]             tid_r;
    logic [10:0]            dest_table_r [NUM_NEURONS];

    logic [NW-1:0]          low_idx_s;
    logic                   pend_any_s;
    logic                   out_free_s;
    logic [10:0]            entry_s;

    // Lowest set pending bit; scanning downward leaves the smallest index last.
    always_comb begin
        low_idx_s = {NW{1'b0}};
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            low_idx_s = pending_r[i] ? NW'(i) : low_idx_s;
        end
    end

    assign pend_any_s = |pending_r;
    // The output register can take a new packet when empty or draining this cycle.
    assign out_free_s = !pkt_valid || pkt_ready;
    // Read returns the pre-write contents when the same entry is written this cycle.
    assign entry_s    = dest_table_r[low_idx_s];

    // Destination table: {en, dest_core, dest_axon}; reset clears every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                dest_table_r[i] <= 11'd0;
            end
        end else if (cfg_we) begin
            dest_table_r[cfg_addr] <= cfg_data;
        end
    end

    // Emission FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            pending_r <= {NUM_NEURONS{1'b0}};
            tid_r     <= 4'd0;
            pkt_valid <= 1'b0;
            pkt_data  <= {PKT_W{1'b0}};
            busy      <= 1'b0;
            tick_done <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tick_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (tick_start) begin
                        pending_r <= spikes;
                        tid_r     <= tick_id;
                        state_r   <= SCAN;
                        busy      <= 1'b1;
                    end
                end
                SCAN: begin
                    if (tick_start) begin
                        overrun <= 1'b1;
                    end
                    if (out_free_s) begin
                        if (pend_any_s) begin
                            pending_r[low_idx_s] <= 1'b0;
                            if (entry_s[10]) begin
                                pkt_data  <= {entry_s[9:8], core_id, entry_s[7:0],
                                              low_idx_s, tid_r, 10'd0};
                                pkt_valid <= 1'b1;
                            end else begin
                                // Disabled entry: spike dropped, slot left empty.
                                pkt_valid <= 1'b0;
                            end
                        end else begin
                            pkt_valid <= 1'b0;
                            state_r   <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (tick_start) begin
                        overrun <= 1'b1;
                    end
                    tick_done <= 1'b1;
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    pkt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer: inputs change on the falling edge,
// outputs are sampled on the falling edge, expected packets are built from
// the hand-chosen table contents.
module tb_spike_packetizer;

    logic         clk;
    logic         rst;
    logic [1:0]   core_id;
    logic         cfg_we;
    logic [7:0]   cfg_addr;
    logic [10:0]  cfg_data;
    logic         tick_start;
    logic [3:0]   tick_id;
    logic [255:0] spikes;
    logic         pkt_valid;
    logic [33:0]  pkt_data;
    logic         pkt_ready;
    logic         busy;
    logic         tick_done;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    logic [33:0] got [16];
    int          got_cyc [16];
    int          n_got;
    int          viol;
    bit          done_seen;

    spike_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .core_id    (core_id),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .tick_start (tick_start),
        .tick_id    (tick_id),
        .spikes     (spikes),
        .pkt_valid  (pkt_valid),
        .pkt_data   (pkt_data),
        .pkt_ready  (pkt_ready),
        .busy       (busy),
        .tick_done  (tick_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] mk_pkt(input logic [1:0] dc, input logic [1:0] sc,
                                           input logic [7:0] ax, input logic [7:0] nr,
                                           input logic [3:0] t);
        return {dc, sc, ax, nr, t, 10'd0};
    endfunction

    task automatic cfg_write(input logic [7:0] a, input logic [10:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic start_tick(input logic [255:0] s, input logic [3:0] t);
        tick_start = 1'b1;
        spikes     = s;
        tick_id    = t;
        @(negedge clk);
        tick_start = 1'b0;
        spikes     = 256'd0;
    endtask

    // Drive pkt_ready, record transfers and stop at tick_done or the budget.
    task automatic collect(input int max_cycles, input int stall_len);
        int          stall_left;
        bit          stalled;
        logic [33:0] hold;
        n_got = 0; viol = 0; done_seen = 1'b0;
        stall_left = 0; stalled = 1'b0; hold = 34'd0;
        for (int c = 0; c < max_cycles && !done_seen; c++) begin
            if (pkt_valid && !stalled && stall_len > 0) begin
                stalled = 1'b1; stall_left = stall_len; hold = pkt_data;
            end
            if (stall_left > 0) begin
                pkt_ready = 1'b0;
                if (pkt_valid !== 1'b1 || pkt_data !== hold) viol++;
                stall_left--;
            end else begin
                pkt_ready = 1'b1;
                if (pkt_valid === 1'b1 && n_got < 16) begin
                    got[n_got] = pkt_data; got_cyc[n_got] = c; n_got++;
                end
            end
            if (tick_done === 1'b1) done_seen = 1'b1;
            else @(negedge clk);
        end
        pkt_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (pkt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", pkt_valid); end
        checks++; if (pkt_data !== 34'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", pkt_data); end
        checks++; if (busy !== 1'b0 || tick_done !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, tick_done, overrun); end
    endtask

    task automatic test_single();
        logic [33:0] exp_p;
        exp_p = mk_pkt(2'd2, 2'd1, 8'd17, 8'd3, 4'd5);
        cfg_write(8'd3, {1'b1, 2'd2, 8'd17});
        start_tick(256'd1 << 3, 4'd5);
        checks++; if (busy !== 1'b1 || pkt_valid !== 1'b0) begin
            failures++; $display("FAIL single_n busy/valid got=%b%b exp=10", busy, pkt_valid); end
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1 || pkt_data !== exp_p) begin
            failures++; $display("FAIL single_pkt got=%b/%h exp=1/%h", pkt_valid, pkt_data, exp_p); end
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b0 || tick_done !== 1'b0) begin
            failures++; $display("FAIL single_after valid/done got=%b%b exp=00", pkt_valid, tick_done); end
        @(negedge clk);
        checks++; if (tick_done !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL single_done done/busy got=%b%b exp=10", tick_done, busy); end
        @(negedge clk);
        checks++; if (tick_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", tick_done); end
    endtask

    task automatic test_multi(input int stall_len, input logic [3:0] t);
        logic [33:0] exp_p [3];
        exp_p[0] = mk_pkt(2'd0, 2'd1, 8'd10,  8'd0,   t);
        exp_p[1] = mk_pkt(2'd3, 2'd1, 8'd200, 8'd1,   t);
        exp_p[2] = mk_pkt(2'd1, 2'd1, 8'd255, 8'd255, t);
        start_tick((256'd1 << 255) | 256'd3, t);
        collect(40, stall_len);
        checks++; if (n_got !== 3) begin failures++; $display("FAIL multi_count stall=%0d got=%0d exp=3", stall_len, n_got); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got[k] !== exp_p[k]) begin
                failures++; $display("FAIL multi_pkt%0d got=%h exp=%h", k, got[k], exp_p[k]); end
        end
        if (stall_len == 0) begin
            checks++; if (got_cyc[1] !== got_cyc[0] + 1 || got_cyc[2] !== got_cyc[0] + 2) begin
                failures++; $display("FAIL multi_b2b got=%0d,%0d,%0d exp consecutive", got_cyc[0], got_cyc[1], got_cyc[2]); end
        end else begin
            checks++; if (viol !== 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", viol); end
        end
        checks++; if (done_seen !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL multi_done done/busy got=%b%b exp=10", done_seen, busy); end
        @(negedge clk);
    endtask

    task automatic test_drop_empty();
        logic [33:0] exp_p;
        exp_p = mk_pkt(2'd2, 2'd1, 8'd44, 8'd4, 4'd3);
        cfg_write(8'd2, {1'b0, 2'd1, 8'd33});
        cfg_write(8'd4, {1'b1, 2'd2, 8'd44});
        start_tick(256'h14, 4'd3);
        collect(40, 0);
        checks++; if (n_got !== 1 || got[0] !== exp_p) begin
            failures++; $display("FAIL drop got=%0d/%h exp=1/%h", n_got, got[0], exp_p); end
        @(negedge clk);
        start_tick(256'd0, 4'd4);
        @(negedge clk);
        checks++; if (tick_done !== 1'b0 || pkt_valid !== 1'b0) begin
            failures++; $display("FAIL empty_n1 done/valid got=%b%b exp=00", tick_done, pkt_valid); end
        @(negedge clk);
        checks++; if (tick_done !== 1'b1 || pkt_valid !== 1'b0) begin
            failures++; $display("FAIL empty_n2 done/valid got=%b%b exp=10", tick_done, pkt_valid); end
        @(negedge clk);
    endtask

    task automatic test_overrun();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
        for (int k = 5; k < 8; k++) cfg_write(8'(k), {1'b1, 2'd0, 8'(k)});
        cfg_write(8'd8, {1'b1, 2'd3, 8'd8});
        start_tick(256'he0, 4'd7);
        start_tick(256'h100, 4'd8);
        collect(40, 0);
        checks++; if (n_got !== 3) begin failures++; $display("FAIL overrun_count got=%0d exp=3", n_got); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (got[k] !== mk_pkt(2'd0, 2'd1, 8'(k + 5), 8'(k + 5), 4'd7)) begin
                failures++; $display("FAIL overrun_pkt%0d got=%h", k, got[k]); end
        end
        repeat (3) @(negedge clk);
        checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL overrun_sticky ovr/busy got=%b%b exp=10", overrun, busy); end
    endtask

    task automatic test_reset_mid();
        pkt_ready = 1'b0;
        start_tick(256'h18, 4'd6);
        @(negedge clk);
        checks++; if (pkt_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got=%b exp=1", pkt_valid); end
        rst = 1'b0;
        #1;
        checks++; if (pkt_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
            failures++; $display("FAIL mid_reset valid/busy/ovr got=%b%b%b exp=000", pkt_valid, busy, overrun); end
        @(negedge clk);
        rst = 1'b1;
        pkt_ready = 1'b1;
        @(negedge clk);
        start_tick(256'd1 << 3, 4'd5);
        collect(40, 0);
        checks++; if (n_got !== 0 || done_seen !== 1'b1) begin
            failures++; $display("FAIL table_cleared pkts/done got=%0d/%b exp=0/1", n_got, done_seen); end
        @(negedge clk);
        test_single();
    endtask

    initial begin
        rst = 1'b0; core_id = 2'd1; cfg_we = 1'b0; cfg_addr = 8'd0; cfg_data = 11'd0;
        tick_start = 1'b0; tick_id = 4'd0; spikes = 256'd0; pkt_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        @(negedge clk);
        test_single();
        cfg_write(8'd0,   {1'b1, 2'd0, 8'd10});
        cfg_write(8'd1,   {1'b1, 2'd3, 8'd200});
        cfg_write(8'd255, {1'b1, 2'd1, 8'd255});
        test_multi(0, 4'd9);
        test_multi(4, 4'd10);
        test_drop_empty();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
